// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and defaults for the memory-stage controller.
//   state_e    : controller FSM encoding (IDLE, BUSY, RESP)
//   accType_e  : access type of the in-flight entry (NONE, LOAD, STORE)
//   decodeAcc  : maps the rd/wr flags of an entry to an access type
package mem_stage_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } accType_e;

  // Exactly one of rd/wr gives a real access; neither or both decode as NONE.
  function automatic accType_e decodeAcc(input logic rd, input logic wr);
    if (rd && !wr) return LOAD;
    else if (wr && !rd) return STORE;
    else return NONE;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: watchdog for an outstanding memory access.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : access is being issued this cycle (counter restarts)
//   run        : controller is waiting in BUSY
//   expired_c  : this is the LIMIT-th BUSY cycle (combinational)
module mem_timeout_ctr #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired_c
);

  localparam int unsigned CntW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CntW-1:0] cnt;

  // Counts completed BUSY cycles; leaving BUSY on expiry keeps it below LIMIT.
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (run)     cnt <= cnt + CntW'(1);
  end

  assign expired_c = run && (cnt == CntW'(LIMIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage access controller between EX/MEM and a
// multi-cycle data memory. Issues one request per memory entry, stalls the
// pipeline until mem_done, then reports completion for one cycle in RESP.
// Optional: define MEM_TIMEOUT_EN to abort a BUSY access after TIMEOUT_CYCLES.
//   in_*                 : EX/MEM entry (valid, rd, wr, halt, addr, wdata)
//   mem_rd/mem_wr/mem_*  : request to memory (issue cycle only), completion in
//   stall_pipe           : freeze upstream stages (issue cycle and BUSY)
//   read_done/write_done : completion pulses in RESP, rdata_out with loads
//   halt                 : sticky halt; err: registered one-cycle error pulse
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_mem_rd,
  input  logic              in_mem_wr,
  input  logic              in_halt,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_pipe,
  output logic              read_done,
  output logic              write_done,
  output logic [DATA_W-1:0] rdata_out,
  output logic              halt,
  output logic              err
);

  state_e            stateQ, stateD;
  accType_e          accQ, accD, reqType;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic [DATA_W-1:0] wdataQ, wdataD, rdataD;
  logic              haltD, errD, readDoneD, writeDoneD;

`ifdef MEM_TIMEOUT_EN
  logic timeoutHit_c;
  logic enterBusy_c;

  assign enterBusy_c = (stateQ == IDLE) && (stateD == BUSY);

  mem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) uTimeout (
    .clk       (clk),
    .rst       (rst),
    .clear     (enterBusy_c),
    .run       (stateQ == BUSY),
    .expired_c (timeoutHit_c)
  );
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= IDLE;
      accQ       <= NONE;
      addrQ      <= '0;
      wdataQ     <= '0;
      rdata_out  <= '0;
      halt       <= 1'b0;
      err        <= 1'b0;
      read_done  <= 1'b0;
      write_done <= 1'b0;
    end else begin
      stateQ     <= stateD;
      accQ       <= accD;
      addrQ      <= addrD;
      wdataQ     <= wdataD;
      rdata_out  <= rdataD;
      halt       <= haltD;
      err        <= errD;
      read_done  <= readDoneD;
      write_done <= writeDoneD;
    end
  end

  // Next state, request/stall outputs and next values of registered outputs.
  always_comb begin
    stateD     = stateQ;
    accD       = accQ;
    addrD      = addrQ;
    wdataD     = wdataQ;
    rdataD     = rdata_out;
    haltD      = halt;
    errD       = 1'b0;
    readDoneD  = 1'b0;
    writeDoneD = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = addrQ;
    mem_wdata  = wdataQ;
    stall_pipe = 1'b0;
    reqType    = decodeAcc(in_mem_rd, in_mem_wr);

    unique case (stateQ)
      IDLE: begin
        if (in_valid && !halt) begin
          if (in_mem_rd || in_mem_wr) begin
            if (reqType == NONE || in_addr[0]) begin
              errD = 1'b1;
            end else begin
              stateD     = BUSY;
              accD       = reqType;
              addrD      = in_addr;
              wdataD     = in_wdata;
              mem_rd     = (reqType == LOAD);
              mem_wr     = (reqType == STORE);
              mem_addr   = in_addr;
              mem_wdata  = in_wdata;
              stall_pipe = 1'b1;
            end
          end else if (in_halt) begin
            haltD = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_pipe = 1'b1;
        if (mem_done) begin
          stateD = RESP;
          if (accQ == LOAD) begin
            rdataD    = mem_rdata;
            readDoneD = 1'b1;
          end else begin
            writeDoneD = 1'b1;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (timeoutHit_c) begin
          stateD = IDLE;
          accD   = NONE;
          errD   = 1'b1;
        end
`endif
      end
      RESP: begin
        stateD = IDLE;
        accD   = NONE;
      end
      default: stateD = IDLE;
    endcase

    // Combinational outputs read as zero while reset is held.
    if (rst) begin
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      stall_pipe = 1'b0;
    end
  end

endmodule
